rsa_modexp_core: RTL

- Parametrised successor to the fixed 1024-bit RSA datapath: computes C = M^E mod N for any operand WIDTH.
- Built from two internal radix-2 bit-serial Montgomery multipliers: a multiply lane and a square lane, running in lockstep.
- Exponent is scanned right-to-left.
- Adds a start/busy/eoc handshake, operand capture, even-modulus error detection and a final conditional subtraction.

---
 rtl/rsa_modexp_core_if.sv | 26 ++
 rtl/rsa_modexp_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core_if.sv
// Handshake and operand bundle for rsa_modexp_core.
// master: the requester driving operands and start; slave: the core.
interface rsa_modexp_core_if #(
   parameter int WIDTH = 1024
);
   logic             en;
   logic             start;
   logic [WIDTH-1:0] N;
   logic [WIDTH-1:0] E;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] R2;
   logic             busy;
   logic             eoc;
   logic             err;
   logic [WIDTH-1:0] C;

   modport master (
      output en, start, N, E, M, R2,
      input  busy, eoc, err, C
   );

   modport slave (
      input  en, start, N, E, M, R2,
      output busy, eoc, err, C
   );
endinterface

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: C = M^E mod N, right-to-left binary exponentiation on two
// lockstep radix-2 bit-serial Montgomery lanes (square lane, multiply lane).
// Intermediates stay in [0, 2N) on WIDTH+2-bit registers; a single
// conditional subtraction at the end brings the result into [0, N).
//
// Optional build macro RSA_EXP_SKIP_EN: stop the exponent loop after the
// highest set bit of E (latency then depends on the exponent length).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands captured on the accepting edge
// CHECK  | reject an even modulus (goes straight to DONE with err)
// LOAD   | clear both accumulators, load lane operands for this phase
// RUN    | WIDTH+2 bit-serial Montgomery steps in both lanes
// STORE  | write lane results back, advance phase / exponent bit
// FINAL  | conditional subtraction A >= N ? A - N : A
// DONE   | drop busy, raise eoc on the next edge, return to IDLE
module rsa_modexp_core #(
   parameter int WIDTH = 1024
) (
   input  logic              clk,
   input  logic              rstb,
   rsa_modexp_core_if.slave  io
);

   localparam int TW = WIDTH + 2;
   localparam int SW = WIDTH + 3;
   localparam int CW = $clog2(TW + 1);
`ifndef RSA_EXP_SKIP_EN
   localparam int LW = $clog2(WIDTH);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_RUN,
      S_STORE,
      S_FINAL,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_CONV,
      PH_LOOP,
      PH_RECONV
   } phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q;

   logic [WIDTH-1:0] n_q, e_q, m_q, r2_q;
   logic [TW-1:0]    xm_q, am_q;
   logic [TW-1:0]    sa_q, sb_q, st_q;
   logic [TW-1:0]    ma_q, mb_q, mt_q;
   logic [TW-1:0]    st_d, mt_d;
   logic [CW-1:0]    run_cnt_q;
`ifndef RSA_EXP_SKIP_EN
   logic [LW-1:0]    loop_cnt_q;
`endif
   logic             loop_last;
   logic             conv_skip;

   logic             busy_q, eoc_q, err_q;
   logic [WIDTH-1:0] c_q;

   logic [TW-1:0]    n_ext, m_ext, r2_ext;

   assign n_ext  = {2'b00, n_q};
   assign m_ext  = {2'b00, m_q};
   assign r2_ext = {2'b00, r2_q};

   // One Montgomery step: add a_i*b, make the sum even with q*N, halve.
   // The sum can reach just under 5N, hence one extra bit of headroom.
   function automatic logic [TW-1:0] mm_step(
      input logic [TW-1:0] t,
      input logic          a_bit,
      input logic [TW-1:0] b,
      input logic [TW-1:0] n
   );
      logic [SW-1:0] s;
      s = {1'b0, t} + (a_bit ? {1'b0, b} : '0);
      s = s + (s[0] ? {1'b0, n} : '0);
      return s[SW-1:1];
   endfunction

   // Next accumulator values for both lanes during RUN.
   always_comb begin
      st_d = mm_step(st_q, sa_q[0], sb_q, n_ext);
      mt_d = mm_step(mt_q, ma_q[0], mb_q, n_ext);
   end

   // Loop termination: fixed count, or stop once no higher exponent bit is set.
   always_comb begin
`ifdef RSA_EXP_SKIP_EN
      loop_last = (e_q[WIDTH-1:1] == '0);
      conv_skip = (e_q == '0);
`else
      loop_last = (loop_cnt_q == '0);
      conv_skip = 1'b0;
`endif
   end

   // FSM state register; en low freezes the sequence.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
         state_q <= S_IDLE;
      else if (io.en)
         state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (io.start) state_d = S_CHECK;
         S_CHECK: state_d = n_q[0] ? S_LOAD : S_DONE;
         S_LOAD:  state_d = S_RUN;
         S_RUN:   if (run_cnt_q == '0) state_d = S_STORE;
         S_STORE: state_d = (phase_q == PH_RECONV) ? S_FINAL : S_LOAD;
         S_FINAL: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath, counters and handshake outputs, all gated by en.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         phase_q    <= PH_CONV;
         n_q        <= '0;
         e_q        <= '0;
         m_q        <= '0;
         r2_q       <= '0;
         xm_q       <= '0;
         am_q       <= '0;
         sa_q       <= '0;
         sb_q       <= '0;
         st_q       <= '0;
         ma_q       <= '0;
         mb_q       <= '0;
         mt_q       <= '0;
         run_cnt_q  <= '0;
`ifndef RSA_EXP_SKIP_EN
         loop_cnt_q <= '0;
`endif
         busy_q     <= 1'b0;
         eoc_q      <= 1'b0;
         err_q      <= 1'b0;
         c_q        <= '0;
      end else if (io.en) begin
         case (state_q)
            S_IDLE: begin
               if (io.start) begin
                  n_q    <= io.N;
                  e_q    <= io.E;
                  m_q    <= io.M;
                  r2_q   <= io.R2;
                  busy_q <= 1'b1;
                  err_q  <= 1'b0;
                  c_q    <= '0;
               end
            end
            S_CHECK: begin
               phase_q    <= PH_CONV;
`ifndef RSA_EXP_SKIP_EN
               loop_cnt_q <= LW'(WIDTH - 1);
`endif
            end
            S_LOAD: begin
               st_q      <= '0;
               mt_q      <= '0;
               run_cnt_q <= CW'(TW - 1);
               case (phase_q)
                  PH_CONV: begin
                     sa_q <= m_ext;
                     sb_q <= r2_ext;
                     ma_q <= TW'(1);
                     mb_q <= r2_ext;
                  end
                  PH_LOOP: begin
                     sa_q <= xm_q;
                     sb_q <= xm_q;
                     ma_q <= am_q;
                     mb_q <= xm_q;
                  end
                  default: begin
                     // Reconvert uses only the multiply lane; the square lane idles on zeros.
                     sa_q <= '0;
                     sb_q <= '0;
                     ma_q <= am_q;
                     mb_q <= TW'(1);
                  end
               endcase
            end
            S_RUN: begin
               st_q      <= st_d;
               mt_q      <= mt_d;
               sa_q      <= sa_q >> 1;
               ma_q      <= ma_q >> 1;
               run_cnt_q <= run_cnt_q - CW'(1);
            end
            S_STORE: begin
               case (phase_q)
                  PH_CONV: begin
                     xm_q    <= st_q;
                     am_q    <= mt_q;
                     phase_q <= conv_skip ? PH_RECONV : PH_LOOP;
                  end
                  PH_LOOP: begin
                     // Multiply result always computed; kept only for a set bit.
                     xm_q <= st_q;
                     if (e_q[0])
                        am_q <= mt_q;
                     e_q <= e_q >> 1;
`ifndef RSA_EXP_SKIP_EN
                     loop_cnt_q <= loop_cnt_q - LW'(1);
`endif
                     if (loop_last)
                        phase_q <= PH_RECONV;
                  end
                  default: begin
                     am_q <= mt_q;
                  end
               endcase
            end
            S_FINAL: begin
               c_q <= (am_q >= n_ext) ? WIDTH'(am_q - n_ext) : WIDTH'(am_q);
            end
            S_DONE: begin
               busy_q <= 1'b0;
               err_q  <= ~n_q[0];
            end
            default: ;
         endcase
         eoc_q <= (state_q == S_DONE);
      end
   end

   assign io.busy = busy_q;
   assign io.eoc  = eoc_q;
   assign io.err  = err_q;
   assign io.C    = c_q;

endmodule
